// File: rtl/cache_fill_fsm_if.sv
// Signal bundle between the block-refill controller and its surroundings:
// the cache lookup (miss request), main memory (issue/return) and the
// cache data/tag arrays (write strobes).
// master = refill controller side, slave = cache/memory side.
interface cache_fill_fsm_if #(
  parameter int AWIDTH          = 16,
  parameter int DWIDTH          = 16,
  parameter int WORDS_PER_BLOCK = 8
);
  localparam int OW = $clog2(WORDS_PER_BLOCK);

  logic              miss_detected;
  logic [AWIDTH-1:0] miss_address;
  logic              fsm_busy;
  logic              mem_read_en;
  logic [AWIDTH-1:0] memory_address;
  logic              memory_data_valid;
  logic [DWIDTH-1:0] memory_data;
  logic              write_data_array;
  logic [OW-1:0]     fill_word_offset;
  logic [DWIDTH-1:0] fill_data;
  logic              write_tag_array;
  logic              fill_done;

  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, mem_read_en, memory_address, write_data_array,
           fill_word_offset, fill_data, write_tag_array, fill_done
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, mem_read_en, memory_address, write_data_array,
           fill_word_offset, fill_data, write_tag_array, fill_done
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: block-refill controller between the cache arrays and the
// pipelined main memory. On a miss it issues one read per cycle for every
// word of the block, writes each returned word into the data array and
// writes the tag together with the last word. fsm_busy stalls the pipeline.
//
// Optional feature macro: CACHE_FILL_CRITICAL_FIRST_EN
//   defined   -> words are issued/returned starting at the missing word
//                (critical word first), wrapping around the block;
//   undefined -> words are issued/returned in order 0..WORDS_PER_BLOCK-1.
// Cycle timing is identical in both builds.
module cache_fill_fsm #(
  parameter int AWIDTH          = 16,
  parameter int DWIDTH          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4
) (
  input logic             clk,
  input logic             rst,
  cache_fill_fsm_if.master bus
);
  localparam int OW = $clog2(WORDS_PER_BLOCK);
  localparam int BW = AWIDTH - OW - 1;  // block-number bits above the byte-in-block field
  localparam logic [OW-1:0] OFS_ONE  = {{(OW-1){1'b0}}, 1'b1};
  localparam logic [OW-1:0] OFS_LAST = OW'(WORDS_PER_BLOCK - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t                 state_r;
  logic [BW-1:0]          block_r;       // captured block number (base >> log2(block bytes))
  logic [OW-1:0]          first_word_r;  // word issued first; always 0 without the feature
  logic [OW-1:0]          issue_cnt_r;
  logic [OW-1:0]          ret_cnt_r;
  logic [MEM_LATENCY-1:0] expect_r;      // one bit per in-flight issue, oldest at the top
  logic                   fsm_busy_r;
  logic                   mem_read_en_r;
  logic [AWIDTH-1:0]      memory_address_r;

  logic [BW-1:0]     miss_block_s;
  logic [OW-1:0]     miss_word_s;
  logic              unused_addr_bits_s;
  logic              accept_s;
  logic              last_ret_s;
  logic [OW-1:0]     ret_offset_s;
  logic [OW-1:0]     next_offset_s;
  logic [DWIDTH-1:0] fill_data_s;

  // Byte address of a word inside a block; the offset field cannot carry
  // into the block number, so the top block wraps within itself.
  function automatic logic [AWIDTH-1:0] block_addr(input logic [BW-1:0] blk,
                                                   input logic [OW-1:0] offset);
    block_addr = {blk, offset, 1'b0};
  endfunction

  assign miss_block_s = bus.miss_address[AWIDTH-1:OW+1];
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
  assign miss_word_s = bus.miss_address[OW:1];
`else
  assign miss_word_s = {OW{1'b0}};
`endif
  // Byte-in-block bits only matter for the critical-word build.
  assign unused_addr_bits_s = ^bus.miss_address[OW:0];

  // Accept a return only if an issue is due this cycle; flag the last word.
  always_comb begin
    accept_s      = 1'b0;
    last_ret_s    = 1'b0;
    ret_offset_s  = first_word_r + ret_cnt_r;
    next_offset_s = first_word_r + issue_cnt_r + OFS_ONE;
    if ((state_r == FILL) && expect_r[MEM_LATENCY-1] && bus.memory_data_valid) begin
      accept_s   = 1'b1;
      last_ret_s = (ret_cnt_r == OFS_LAST);
    end else begin
      accept_s   = 1'b0;
      last_ret_s = 1'b0;
    end
  end

  // Fill sequencer: state, counters, return tracker and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      block_r          <= {BW{1'b0}};
      first_word_r     <= {OW{1'b0}};
      issue_cnt_r      <= {OW{1'b0}};
      ret_cnt_r        <= {OW{1'b0}};
      expect_r         <= {MEM_LATENCY{1'b0}};
      fsm_busy_r       <= 1'b0;
      mem_read_en_r    <= 1'b0;
      memory_address_r <= {AWIDTH{1'b0}};
    end else begin
      expect_r <= (expect_r << 1'b1) | MEM_LATENCY'(mem_read_en_r);
      case (state_r)
        IDLE: begin
          if (bus.miss_detected) begin
            state_r          <= FILL;
            block_r          <= miss_block_s;
            first_word_r     <= miss_word_s;
            issue_cnt_r      <= {OW{1'b0}};
            ret_cnt_r        <= {OW{1'b0}};
            fsm_busy_r       <= 1'b1;
            mem_read_en_r    <= 1'b1;
            memory_address_r <= block_addr(miss_block_s, miss_word_s);
          end else begin
            state_r <= IDLE;
          end
        end
        FILL: begin
          if (mem_read_en_r) begin
            issue_cnt_r <= issue_cnt_r + OFS_ONE;
            if (issue_cnt_r == OFS_LAST) begin
              mem_read_en_r    <= 1'b0;
              memory_address_r <= {AWIDTH{1'b0}};
            end else begin
              memory_address_r <= block_addr(block_r, next_offset_s);
            end
          end
          if (accept_s) begin
            ret_cnt_r <= ret_cnt_r + OFS_ONE;
          end
          if (last_ret_s) begin
            state_r    <= IDLE;
            fsm_busy_r <= 1'b0;
          end
        end
        default: begin
          state_r       <= IDLE;
          fsm_busy_r    <= 1'b0;
          mem_read_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign fill_data_s          = bus.memory_data;
  assign bus.fill_data        = fill_data_s;
  assign bus.fsm_busy         = fsm_busy_r;
  assign bus.mem_read_en      = mem_read_en_r;
  assign bus.memory_address   = memory_address_r;
  assign bus.write_data_array = accept_s;
  assign bus.fill_word_offset = accept_s ? ret_offset_s : {OW{1'b0}};
  assign bus.write_tag_array  = last_ret_s;
  assign bus.fill_done        = last_ret_s;
endmodule
